mest_pro_display_scan: RTL
==========================

MEST_PRO_DISPLAY_SCAN -- requirements
Module: mest_pro_display_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed 7-segment digits.
REQ-002 SHALL have parameter REFRESH_DIV, default 1000: clk cycles each digit is selected; legal range 4..65535.
REQ-003 SHALL have parameter BLANK_LEADING, default 1: 1 = suppress leading-zero digits.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_output_enable, input, 1: load strobe; i_data is sampled on any clk edge where this is high.
REQ-007 SHALL have port i_data, input, 4*DIGITS: value to display; nibble k drives digit k, where digit 0 is least significant.
REQ-008 SHALL have port o_nibble, output, 4: hex value of the current digit, fed to the downstream 7-segment decoder.
REQ-009 SHALL have port o_digit_en, output, DIGITS: active-high digit select; one-hot or all-zero.
REQ-010 SHALL have port o_frame_done, output, 1: one-cycle pulse after the last digit of each frame.

Function
REQ-011 SHALL implement FSM states IDLE (nothing loaded) and SCAN; reset state is IDLE.
REQ-012 In IDLE, o_digit_en SHALL be 0, o_nibble SHALL be 0 and the refresh counter SHALL hold at 0.
REQ-013 In IDLE, i_output_enable=1 SHALL load the shadow register with i_data, set idx=0 and counter=0, and move the FSM to SCAN on the same edge.
REQ-014 In SCAN, the refresh counter SHALL count 0..REFRESH_DIV-1 and then wrap to 0; at the terminal count idx SHALL advance by 1.
REQ-015 At the terminal count with idx=DIGITS-1, idx SHALL wrap to 0 and o_frame_done SHALL be 1 for exactly the following cycle.
REQ-016 In SCAN, i_output_enable=1 SHALL write i_data to a pending register and set pend_valid; the last strobe before a frame wrap wins.
REQ-017 At frame wrap, if pend_valid=1, pending SHALL be copied to shadow and pend_valid cleared; the displayed value changes only at frame boundaries (no tearing).
REQ-018 If the strobe coincides with the frame-wrap edge, the i_data presented on that edge SHALL go directly to shadow and pend_valid SHALL end at 0.
REQ-019 o_nibble SHALL be registered: o_nibble = shadow[4*idx +: 4], valid one cycle after idx changes.
REQ-020 o_digit_en SHALL be registered one cycle after o_nibble, aligning with the downstream decoder's one-cycle registered output.
REQ-021 On every idx change, o_digit_en SHALL be all-zero for at least one cycle (dead time, anti-ghosting) before the new digit's bit asserts.
REQ-022 With BLANK_LEADING=1, digit k SHALL be blanked (its o_digit_en bit kept 0 while o_nibble still updates) when all shadow nibbles from DIGITS-1 down to k are 0 and k>0.
REQ-023 Digit 0 SHALL never be blanked, so value 0 displays a single "0".
REQ-024 Blanking SHALL be evaluated on shadow, never on pending.
REQ-025 Counter width SHALL be clog2(REFRESH_DIV) and idx width SHALL be clog2(DIGITS) with a minimum of 1; no overflow beyond the wrap points.

Reset
REQ-026 While rst_n=0, o_nibble=0, o_digit_en=0, o_frame_done=0, FSM=IDLE, shadow=0, pending=0, pend_valid=0, idx=0 and counter=0, asynchronously.
REQ-027 Deassertion of rst_n SHALL take effect at the next clk edge; reset asserted mid-frame SHALL abort the scan and return to IDLE, requiring a new strobe.

Verification (DIGITS=4, REFRESH_DIV=4, BLANK_LEADING=1)
REQ-028 Post-reset, no strobe for 50 cycles -> o_digit_en=0, o_nibble=0, o_frame_done never asserts.
REQ-029 Strobe i_data=16'h1A3F -> o_nibble steps F,3,A,1 every 4 cycles; o_digit_en steps 0001,0010,0100,1000 one cycle behind o_nibble, with one zero cycle between digits; o_frame_done pulses every 16 cycles.
REQ-030 Strobe 16'h0005 -> only o_digit_en=0001 ever asserts, showing 5; strobe 16'h0000 -> only digit 0 asserts, with o_nibble=0.
REQ-031 While scanning 16'h1234, strobe 16'hABCD mid-frame, then 16'h5678 -> the current frame completes as 4,3,2,1 and the next frame shows 8,7,6,5; ABCD is never displayed.
REQ-032 Strobe 16'h9999 on the exact frame-wrap edge -> the next frame's first o_nibble is 9 and pend_valid=0.
REQ-033 Drop rst_n during digit 2 -> o_digit_en=0 immediately without waiting for clk; after release the block stays dark until a new strobe arrives.

Source files
------------

// File: rtl/mest_pro_display_scan.sv
// mest_pro_display_scan: multiplexed 7-segment digit scanner with frame-synchronous
// value updates, dead time between digits and optional leading-zero blanking.
module mest_pro_display_scan #(
    parameter int DIGITS        = 4,
    parameter int REFRESH_DIV   = 1000,
    parameter int BLANK_LEADING = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_output_enable,
    input  logic [4*DIGITS-1:0] i_data,
    output logic [3:0]          o_nibble,
    output logic [DIGITS-1:0]   o_digit_en,
    output logic                o_frame_done
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, SCAN} state_e;

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d, nib_idx_q;
    logic [4*DIGITS-1:0] shadow_q, shadow_d, pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;
    logic [3:0]          nibble_q, nibble_d;
    logic [DIGITS-1:0]   en_q, en_d, blank;
    logic                nib_act_q, done_q, done_d, zero_run;
    logic                tc, last, wrap;

    assign tc   = cnt_q == CW'(REFRESH_DIV - 1);
    assign last = idx_q == IW'(DIGITS - 1);
    assign wrap = state_q == SCAN && tc && last;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state_q <= IDLE;
        else state_q <= state_d;

    always_comb state_d = (state_q == IDLE && i_output_enable) ? SCAN : state_q;

    // A digit is blanked when it and every more significant nibble are zero.
    always_comb begin
        blank    = '0;
        zero_run = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && shadow_q[4*k +: 4] == 4'h0;
            blank[k] = BLANK_LEADING != 0 && zero_run && k > 0;
        end
    end

    always_comb begin
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (state_q == IDLE) begin
            if (i_output_enable) begin
                shadow_d = i_data;
                cnt_d    = '0;
                idx_d    = '0;
            end
        end else begin
            cnt_d = tc ? '0 : cnt_q + CW'(1);
            if (tc) idx_d = last ? '0 : idx_q + IW'(1);
            if (wrap) begin
                shadow_d     = i_output_enable ? i_data : pend_valid_q ? pend_q : shadow_q;
                pend_valid_d = 1'b0;
            end else if (i_output_enable) begin
                pend_d       = i_data;
                pend_valid_d = 1'b1;
            end
        end
    end

    // Digit enable follows the nibble by one cycle and stays dark whenever idx just moved.
    always_comb begin
        nibble_d = state_q == SCAN ? shadow_q[4*idx_q +: 4] : 4'h0;
        en_d     = (nib_act_q && nib_idx_q == idx_q && !blank[nib_idx_q]) ? DIGITS'(1) << nib_idx_q : '0;
        done_d   = wrap;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            nib_idx_q    <= '0;
            shadow_q     <= '0;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            nibble_q     <= '0;
            nib_act_q    <= 1'b0;
            en_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            nib_idx_q    <= idx_q;
            shadow_q     <= shadow_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            nibble_q     <= nibble_d;
            nib_act_q    <= state_q == SCAN;
            en_q         <= en_d;
            done_q       <= done_d;
        end

    assign o_nibble     = nibble_q;
    assign o_digit_en   = en_q;
    assign o_frame_done = done_q;
endmodule
